// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: sequencer for icache CAM writes.
// It has two jobs:
//   - Refill: on a fetch miss, read one aligned line critical word first and
//     write data, tag and flags for each word as it arrives.
//   - Flush: sweep all 1024 CAM entries and clear their tag/flags.
// Only one operation runs at a time. Flush wins over a miss when both are pending in IDLE.
module icache_refill_ctrl #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk_core,
  input  logic        reset,
  input  logic        miss_req,
  input  logic [26:0] miss_paddr,
  output logic        miss_done,
  input  logic        flush_req,
  output logic        flush_done,
  output logic        busy,
  output logic        mem_read_req,
  output logic [26:0] mem_read_addr,
  input  logic        mem_read_ack,
  input  logic        mem_read_err,
  input  logic [31:0] mem_read_data,
  output logic [9:0]  cam_write_index,
  output logic        cam_write_req_data,
  output logic [31:0] cam_write_data,
  output logic        cam_write_req_tag_flags,
  output logic [16:0] cam_write_tag,
  output logic [1:0]  cam_write_flags
);

  localparam int          OFF_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [26:0] OFF_MASK = 27'(LINE_WORDS - 1);
  localparam logic [9:0]  LAST_IDX = 10'd1023;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_FILL_DONE,
    S_FLUSH,
    S_FLUSH_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [26:0]        line_q;       // line base word address, offset bits cleared
  logic [OFF_W-1:0]   start_q;      // critical word offset within the line
  logic [OFF_W-1:0]   count_q;      // words already written in this fill
  logic [16:0]        tag_q;
  logic [9:0]         flush_cnt_q;

  logic [OFF_W-1:0]   word_off;
  logic [26:0]        word_addr;
  logic               last_word;

  // The offset wraps modulo the line size, so the fill stays inside the aligned line.
  assign word_off  = start_q + count_q;
  assign word_addr = line_q | ({{(27 - OFF_W){1'b0}}, word_off} & OFF_MASK);
  assign last_word = (count_q == OFF_W'(LINE_WORDS - 1));

  // State register and the per-operation counters and latches.
  always_ff @(posedge clk_core) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      line_q      <= '0;
      start_q     <= '0;
      count_q     <= '0;
      tag_q       <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (flush_req) begin
            flush_cnt_q <= '0;
          end else if (miss_req) begin
            line_q  <= miss_paddr & ~OFF_MASK;
            start_q <= miss_paddr[OFF_W-1:0];
            tag_q   <= miss_paddr[26:10];
            count_q <= '0;
          end
        end
        S_FILL: begin
          if (mem_read_ack && !last_word) count_q <= count_q + 1'b1;
        end
        S_FLUSH: begin
          if (flush_cnt_q != LAST_IDX) flush_cnt_q <= flush_cnt_q + 10'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and output decode from registered state; the fill write also uses ack/data.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d                 = state_q;
    miss_done               = 1'b0;
    flush_done              = 1'b0;
    mem_read_req            = 1'b0;
    mem_read_addr           = '0;
    cam_write_index         = '0;
    cam_write_req_data      = 1'b0;
    cam_write_data          = '0;
    cam_write_req_tag_flags = 1'b0;
    cam_write_tag           = '0;
    cam_write_flags         = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (flush_req)     state_d = S_FLUSH;
        else if (miss_req) state_d = S_FILL;
      end
      S_FILL: begin
        mem_read_req  = 1'b1;
        mem_read_addr = word_addr;
        if (mem_read_ack) begin
          cam_write_req_data      = 1'b1;
          cam_write_req_tag_flags = 1'b1;
          cam_write_index         = word_addr[9:0];
          cam_write_data          = mem_read_data;
          cam_write_tag           = tag_q;
          cam_write_flags         = {mem_read_err, 1'b1};
          if (last_word) state_d = S_FILL_DONE;
        end
      end
      S_FILL_DONE: begin
        miss_done = 1'b1;
        state_d   = S_IDLE;
      end
      S_FLUSH: begin
        cam_write_req_tag_flags = 1'b1;
        cam_write_index         = flush_cnt_q;
        if (flush_cnt_q == LAST_IDX) state_d = S_FLUSH_DONE;
      end
      S_FLUSH_DONE: begin
        flush_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed testbench for icache_refill_ctrl.
// It acts as both the fetch requester and the memory port. Inputs change on
// the falling edge, and outputs are sampled 1 ns later.
module tb_icache_refill_ctrl;

  logic        clk_core = 1'b0;
  logic        reset;
  logic        miss_req;
  logic [26:0] miss_paddr;
  logic        miss_done;
  logic        flush_req;
  logic        flush_done;
  logic        busy;
  logic        mem_read_req;
  logic [26:0] mem_read_addr;
  logic        mem_read_ack;
  logic        mem_read_err;
  logic [31:0] mem_read_data;
  logic [9:0]  cam_write_index;
  logic        cam_write_req_data;
  logic [31:0] cam_write_data;
  logic        cam_write_req_tag_flags;
  logic [16:0] cam_write_tag;
  logic [1:0]  cam_write_flags;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  icache_refill_ctrl #(.LINE_WORDS(4)) dut (
    .clk_core                (clk_core),
    .reset                   (reset),
    .miss_req                (miss_req),
    .miss_paddr              (miss_paddr),
    .miss_done               (miss_done),
    .flush_req               (flush_req),
    .flush_done              (flush_done),
    .busy                    (busy),
    .mem_read_req            (mem_read_req),
    .mem_read_addr           (mem_read_addr),
    .mem_read_ack            (mem_read_ack),
    .mem_read_err            (mem_read_err),
    .mem_read_data           (mem_read_data),
    .cam_write_index         (cam_write_index),
    .cam_write_req_data      (cam_write_req_data),
    .cam_write_data          (cam_write_data),
    .cam_write_req_tag_flags (cam_write_req_tag_flags),
    .cam_write_tag           (cam_write_tag),
    .cam_write_flags         (cam_write_flags)
  );

  always #5 clk_core = ~clk_core;
  always @(posedge clk_core) cyc <= cyc + 1;

  logic [93:0] all_out;
  always_comb all_out = {miss_done, flush_done, busy, mem_read_req, mem_read_addr,
                         cam_write_index, cam_write_req_data, cam_write_data,
                         cam_write_req_tag_flags, cam_write_tag, cam_write_flags};

  // Memory contents model: a fixed pattern derived from the word address.
  function automatic logic [31:0] mem_data(input logic [26:0] a);
    return {5'b10110, a} ^ 32'h0F0F_0000;
  endfunction

  // Expected write record: {addr, index, tag, flags, data}.
  function automatic logic [87:0] exp_rec(input logic [31:0] byte_a, input logic [16:0] tag,
                                          input logic [1:0] fl);
    logic [26:0] a;
    a = byte_a[28:2];
    return {a, a[9:0], tag, fl, mem_data(a)};
  endfunction

  // Observations from the last fill.
  int          n_wr;
  int          stray;
  bit          both_ok;
  bit          addr_moved;
  bit          fill_timeout;
  bit          req_at_done;
  int          last_ack_cyc;
  int          done_cyc;
  logic [87:0] obs_rec [4];

  // Observations from the last flush.
  int fl_wr;
  int fl_seq_err;
  int fl_field_err;
  int fl_bus;
  int fl_done_cyc;
  bit fl_timeout;

  task automatic start_miss(input logic [31:0] byte_a);
    @(negedge clk_core);
    miss_paddr = byte_a[28:2];
    miss_req   = 1'b1;
  endtask

  // Serve one fill as the memory port and record every CAM write.
  // The word-0 ack comes delay0 cycles after the request, and later words get one cycle.
  // The read at position err_word returns an error. flush_req is raised when the
  // fill reaches position flush_at_word.
  task automatic run_fill(input int delay0, input int err_word, input int flush_at_word);
    int          word = 0;
    int          wait_cnt = 0;
    logic [26:0] prev_addr = '0;
    n_wr = 0; stray = 0; both_ok = 1'b1; addr_moved = 1'b0; fill_timeout = 1'b1;
    req_at_done = 1'b1; last_ack_cyc = 0; done_cyc = 0;
    for (int i = 0; i < 4; i++) obs_rec[i] = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_core);
      mem_read_ack = 1'b0; mem_read_err = 1'b0; mem_read_data = '0;
      if (flush_at_word >= 0 && word == flush_at_word) flush_req = 1'b1;
      if (mem_read_req) begin
        if (wait_cnt > 0 && mem_read_addr !== prev_addr) addr_moved = 1'b1;
        prev_addr = mem_read_addr;
        wait_cnt++;
        if (wait_cnt > ((word == 0) ? delay0 : 1)) begin
          mem_read_ack  = 1'b1;
          mem_read_data = mem_data(mem_read_addr);
          mem_read_err  = (word == err_word);
        end
      end
      #1;
      if (cam_write_req_data || cam_write_req_tag_flags) begin
        if (!mem_read_ack || n_wr >= 4) stray++;
        else begin
          if (!(cam_write_req_data && cam_write_req_tag_flags)) both_ok = 1'b0;
          obs_rec[n_wr] = {mem_read_addr, cam_write_index, cam_write_tag, cam_write_flags,
                           cam_write_data};
          n_wr++;
        end
      end
      if (mem_read_ack && mem_read_req) begin
        last_ack_cyc = cyc; word++; wait_cnt = 0;
      end
      if (miss_done) begin
        done_cyc = cyc; req_at_done = mem_read_req; miss_req = 1'b0; fill_timeout = 1'b0;
        break;
      end
    end
    mem_read_ack = 1'b0; mem_read_err = 1'b0;
  endtask

  // Watch a flush sweep until flush_done and record its writes.
  task automatic run_flush();
    fl_wr = 0; fl_seq_err = 0; fl_field_err = 0; fl_bus = 0; fl_done_cyc = 0; fl_timeout = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk_core);
      #1;
      if (mem_read_req || cam_write_req_data) fl_bus++;
      if (cam_write_req_tag_flags) begin
        if (cam_write_index !== fl_wr[9:0]) fl_seq_err++;
        if (cam_write_tag !== 17'd0 || cam_write_flags !== 2'b00) fl_field_err++;
        fl_wr++;
      end
      if (flush_done) begin
        fl_done_cyc = cyc; flush_req = 1'b0; fl_timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    miss_req = 1'b0; miss_paddr = '0; flush_req = 1'b0;
    mem_read_ack = 1'b0; mem_read_err = 1'b0; mem_read_data = '0;
    repeat (3) @(negedge clk_core);
    #1;
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_fill_wrap();
    logic [31:0] exp_b [4] = '{32'h0001_1008, 32'h0001_100C, 32'h0001_1000, 32'h0001_1004};
    start_miss(32'h0001_1008);
    run_fill(1, -1, -1);
    total++;
    if (fill_timeout || n_wr != 4 || stray != 0 || !both_ok) begin
      bad++; $display("FAIL wrap_count: got to=%0d wr=%0d stray=%0d both=%0d want 0 4 0 1",
                      fill_timeout, n_wr, stray, both_ok);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_rec[i] !== exp_rec(exp_b[i], 17'h00011, 2'b01)) begin
        bad++; $display("FAIL wrap_word%0d: got %h want %h", i, obs_rec[i],
                        exp_rec(exp_b[i], 17'h00011, 2'b01));
      end
    end
    total++;
    if (done_cyc - last_ack_cyc != 1 || req_at_done !== 1'b0) begin
      bad++; $display("FAIL wrap_done_latency: got %0d req=%0d want 1 req=0",
                      done_cyc - last_ack_cyc, req_at_done);
    end
    @(negedge clk_core); #1;
    total++;
    if (miss_done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL wrap_idle_after: got done=%0d busy=%0d want 0 0", miss_done, busy);
    end
  endtask

  task automatic test_ack_stall();
    logic [31:0] exp_b [4] = '{32'h0ABC_DEF4, 32'h0ABC_DEF8, 32'h0ABC_DEFC, 32'h0ABC_DEF0};
    start_miss(32'h0ABC_DEF4);
    run_fill(3, -1, -1);
    total++;
    if (fill_timeout || addr_moved || stray != 0 || n_wr != 4) begin
      bad++; $display("FAIL stall_hold: got to=%0d moved=%0d stray=%0d wr=%0d want 0 0 0 4",
                      fill_timeout, addr_moved, stray, n_wr);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_rec[i] !== exp_rec(exp_b[i], 17'h0ABCD, 2'b01)) begin
        bad++; $display("FAIL stall_word%0d: got %h want %h", i, obs_rec[i],
                        exp_rec(exp_b[i], 17'h0ABCD, 2'b01));
      end
    end
  endtask

  task automatic test_bus_error();
    logic [31:0] exp_b [4] = '{32'h0000_0004, 32'h0000_0008, 32'h0000_000C, 32'h0000_0000};
    logic [1:0]  exp_f [4] = '{2'b01, 2'b11, 2'b01, 2'b01};
    start_miss(32'h0000_0004);
    run_fill(1, 1, -1);
    total++;
    if (fill_timeout || n_wr != 4) begin
      bad++; $display("FAIL err_complete: got to=%0d wr=%0d want 0 4", fill_timeout, n_wr);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_rec[i] !== exp_rec(exp_b[i], 17'h00000, exp_f[i])) begin
        bad++; $display("FAIL err_word%0d: got %h want %h", i, obs_rec[i],
                        exp_rec(exp_b[i], 17'h00000, exp_f[i]));
      end
    end
  endtask

  task automatic test_flush();
    int acc;
    @(negedge clk_core);
    flush_req = 1'b1;
    acc = cyc;
    run_flush();
    total++;
    if (fl_timeout || fl_wr != 1024 || fl_seq_err != 0 || fl_field_err != 0 || fl_bus != 0) begin
      bad++; $display("FAIL flush_sweep: got to=%0d wr=%0d seq=%0d fld=%0d bus=%0d want 0 1024 0 0 0",
                      fl_timeout, fl_wr, fl_seq_err, fl_field_err, fl_bus);
    end
    total++;
    if (fl_done_cyc - acc + 1 != 1026) begin
      bad++; $display("FAIL flush_latency: got %0d want 1026", fl_done_cyc - acc + 1);
    end
    @(negedge clk_core); #1;
    total++;
    if (flush_done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL flush_idle_after: got done=%0d busy=%0d want 0 0", flush_done, busy);
    end
  endtask

  task automatic test_arb_simultaneous();
    logic [31:0] exp_b [4] = '{32'h0001_1008, 32'h0001_100C, 32'h0001_1000, 32'h0001_1004};
    @(negedge clk_core);
    flush_req  = 1'b1;
    miss_paddr = 27'h0004402;
    miss_req   = 1'b1;
    run_flush();
    total++;
    if (fl_timeout || fl_wr != 1024 || fl_bus != 0) begin
      bad++; $display("FAIL arb_flush_first: got to=%0d wr=%0d bus=%0d want 0 1024 0",
                      fl_timeout, fl_wr, fl_bus);
    end
    run_fill(1, -1, -1);
    total++;
    if (fill_timeout || n_wr != 4 || obs_rec[0] !== exp_rec(exp_b[0], 17'h00011, 2'b01)
        || obs_rec[3] !== exp_rec(exp_b[3], 17'h00011, 2'b01)) begin
      bad++; $display("FAIL arb_fill_after: got to=%0d wr=%0d w0=%h want 0 4 %h",
                      fill_timeout, n_wr, obs_rec[0], exp_rec(exp_b[0], 17'h00011, 2'b01));
    end
  endtask

  task automatic test_arb_mid_fill();
    logic [31:0] exp_b [4] = '{32'h0001_1008, 32'h0001_100C, 32'h0001_1000, 32'h0001_1004};
    int nbad = 0;
    start_miss(32'h0001_1008);
    run_fill(1, -1, 2);
    for (int i = 0; i < 4; i++)
      if (obs_rec[i] !== exp_rec(exp_b[i], 17'h00011, 2'b01)) nbad++;
    total++;
    if (fill_timeout || n_wr != 4 || stray != 0 || nbad != 0 || flush_req !== 1'b1) begin
      bad++; $display("FAIL midfill_fill: got to=%0d wr=%0d stray=%0d badw=%0d want 0 4 0 0",
                      fill_timeout, n_wr, stray, nbad);
    end
    run_flush();
    total++;
    if (fl_timeout || fl_wr != 1024 || fl_seq_err != 0 || fl_done_cyc - (done_cyc + 1) + 1 != 1026) begin
      bad++; $display("FAIL midfill_flush: got to=%0d wr=%0d seq=%0d lat=%0d want 0 1024 0 1026",
                      fl_timeout, fl_wr, fl_seq_err, fl_done_cyc - done_cyc);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] exp_b [4] = '{32'h0001_1008, 32'h0001_100C, 32'h0001_1000, 32'h0001_1004};
    int acks = 0;
    int wait_cnt = 0;
    start_miss(32'h0001_1008);
    for (int c = 0; c < 50 && acks < 2; c++) begin
      @(negedge clk_core);
      mem_read_ack = 1'b0;
      if (mem_read_req) begin
        wait_cnt++;
        if (wait_cnt > 1) begin
          mem_read_ack = 1'b1; mem_read_data = mem_data(mem_read_addr);
        end
      end
      #1;
      if (mem_read_ack && mem_read_req) begin acks++; wait_cnt = 0; end
    end
    total++;
    if (acks != 2) begin
      bad++; $display("FAIL rst_setup_acks: got %0d want 2", acks);
    end
    @(negedge clk_core);
    mem_read_ack = 1'b0; reset = 1'b1; miss_req = 1'b0;
    @(negedge clk_core);
    reset = 1'b0; mem_read_ack = 1'b1; mem_read_data = 32'hDEAD_BEEF;
    #1;
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL rst_midfill_outputs: got %h want 0", all_out);
    end
    @(negedge clk_core);
    mem_read_ack = 1'b0;
    #1;
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL rst_late_ack: got %h want 0", all_out);
    end
    start_miss(32'h0001_1008);
    run_fill(1, -1, -1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (fill_timeout || obs_rec[i] !== exp_rec(exp_b[i], 17'h00011, 2'b01)) begin
        bad++; $display("FAIL rst_refill_word%0d: got %h want %h", i, obs_rec[i],
                        exp_rec(exp_b[i], 17'h00011, 2'b01));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_wrap();
    test_ack_stall();
    test_bus_error();
    test_flush();
    test_arb_simultaneous();
    test_arb_mid_fill();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
